demux16_8_buf: RTL and testbench
================================

# demux16_8_buf

Registered 1-to-8 distributor for 16-bit words: the write-side counterpart of the 8:1 16-bit selector. A single producer presents a word with a 3-bit destination under a valid/ready handshake. The block captures the word into one of eight per-channel holding registers, and each channel's consumer drains it with a valid/ack pair. It sits between a shared datapath bus and eight independent downstream lanes.

## Interface
Parameters
- None. Widths are fixed: 16-bit data, 8 channels, 3-bit select.

Ports
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_data  input  16  word to distribute.
- in_sel  input  3  destination channel 0..7. Channel 0 corresponds to lane a and channel 7 to lane h.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept the word this cycle. Combinational.
- out_bus  output  128  channel k holding register at bits [16k+15:16k].
- out_valid  output  8  bit k is high while channel k holds an unconsumed word.
- out_ack  input  8  bit k consumes channel k's word. Has effect only while out_valid[k] is high.
- xfer_cnt  output  16  count of accepted input transfers; wraps modulo 2^16.
- bcast  input  1  broadcast request. Present only with DEMUX_BCAST_EN.

## Operation
- free[k] = ~out_valid[k] | out_ack[k]. A channel is free if it is empty, or if it is being drained this cycle.
- Unicast handshake:
  - in_ready = free[in_sel].
  - An accept occurs when in_valid & in_ready are both high.
- On an accept:
  - out_bus[in_sel] <= in_data.
  - out_valid[in_sel] <= 1.
  - xfer_cnt <= xfer_cnt + 1.
- Drain: when out_ack[k] & out_valid[k] and there is no accept into channel k, out_valid[k] <= 0. out_bus[k] keeps its last value; it is not cleared.
- Simultaneous ack and accept on the same channel (refill):
  - The new word is written.
  - out_valid[k] stays 1.
  - There is no bubble.
- Ack on an empty channel is ignored. Acks on several channels in the same cycle are each honoured independently.
- in_ready may be sampled while in_valid is low. The producer must hold in_data and in_sel stable until the accept.
- A stalled word is never lost or duplicated. The block holds no internal copy of a word before it is accepted.
- No state machine beyond the per-channel valid flags: each channel is EMPTY (valid=0) or FULL (valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ack without accept.
  - FULL -> FULL on ack with accept, or on no ack.
- Reset takes priority over any accept or ack in the same cycle, including in the middle of a stall or refill.

## Timing
- Reset values: out_valid = 8'h00, out_bus = 128'h0, xfer_cnt = 16'h0.
- in_ready is combinational in in_sel, out_valid and out_ack, and is low while rst_n is low.
- Latency: a word accepted at edge N appears on out_bus with out_valid high immediately after edge N, i.e. one cycle.
- Throughput: one word per cycle, including a sustained stream into a single channel whose consumer acks every cycle.
- xfer_cnt updates on the same edge as the accept. 16'hFFFF + 1 wraps to 16'h0000.

## Configuration
- DEMUX_BCAST_EN defined: adds the bcast input.
  - When bcast=1, in_sel is ignored.
  - in_ready = AND of free[0..7].
  - An accept writes in_data to all 8 channels, sets out_valid = 8'hFF, and increments xfer_cnt by 1.
  - Per-channel acks in the same cycle do not clear the valid flags.
- DEMUX_BCAST_EN undefined: the bcast port does not exist and behaviour is unicast only.

## Test plan
- Reset: assert rst_n=0 for 2 cycles with in_valid=1 and out_ack=8'hFF -> out_valid=0, out_bus=0, xfer_cnt=0, in_ready=0.
- Fill all channels: write 16'h1000+k to sel=k for k=0..7, no acks -> out_valid=8'hFF, each lane equals 16'h1000+k, xfer_cnt=8. Then sel=3 with in_valid=1 -> in_ready=0 and nothing changes.
- Stall then release: channel 5 full, producer holds 16'hBEEF on sel=5 for 3 cycles, then out_ack[5]=1 -> accepted in the ack cycle, lane 5 = 16'hBEEF, out_valid[5] stays 1, xfer_cnt increments exactly once.
- Back-to-back refill: 100 consecutive words to sel=2 with out_ack[2] held high -> in_ready constantly 1, consumer sees every word in order, xfer_cnt=100.
- Wrap and spurious ack: preload xfer_cnt to 16'hFFFF via 65535 writes, then one more -> xfer_cnt=0. out_ack=8'h01 on an empty channel 0 -> no change.
- (DEMUX_BCAST_EN) With channel 6 full, broadcast 16'hA5A5 -> stalls. Ack channel 6 in that cycle -> all lanes = 16'hA5A5, out_valid=8'hFF.

Source files
------------

// File: rtl/demux16_8_buf_if.sv
// Producer/consumer bundle for demux16_8_buf.
// The bcast signal exists only when DEMUX_BCAST_EN is defined.
interface demux16_8_buf_if;
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_bus;
  logic [7:0]   out_valid;
  logic [7:0]   out_ack;
  logic [15:0]  xfer_cnt;
`ifdef DEMUX_BCAST_EN
  logic         bcast;

  modport slave (
    input  in_data, in_sel, in_valid, out_ack, bcast,
    output in_ready, out_bus, out_valid, xfer_cnt
  );
  modport master (
    output in_data, in_sel, in_valid, out_ack, bcast,
    input  in_ready, out_bus, out_valid, xfer_cnt
  );
`else
  modport slave (
    input  in_data, in_sel, in_valid, out_ack,
    output in_ready, out_bus, out_valid, xfer_cnt
  );
  modport master (
    output in_data, in_sel, in_valid, out_ack,
    input  in_ready, out_bus, out_valid, xfer_cnt
  );
`endif
endinterface

// File: rtl/demux16_8_buf.sv
// Registered 1-to-8 distributor of 16-bit words with per-channel valid/ack drain.
// Optional broadcast path enabled by defining DEMUX_BCAST_EN.
module demux16_8_buf (
  input  logic             clk,
  input  logic             rst_n,
  demux16_8_buf_if.slave   bus
);
  localparam int DATA_W = 16;
  localparam int NCH    = 8;

  logic [NCH-1:0]             w_free;
  logic [NCH-1:0]             w_wr;
  logic                       w_ready;
  logic                       w_accept;

  logic [NCH-1:0][DATA_W-1:0] r_bus_p1;
  logic [NCH-1:0]             r_vld_p1;
  logic [DATA_W-1:0]          r_cnt_p1;

  // A channel being drained this cycle can be refilled on the same edge.
  always_comb begin
    w_free   = ~r_vld_p1 | bus.out_ack;
    w_ready  = 1'b0;
    w_accept = 1'b0;
    w_wr     = '0;
`ifdef DEMUX_BCAST_EN
    if (bus.bcast) begin
      w_ready  = rst_n & (&w_free);
      w_accept = bus.in_valid & w_ready;
      w_wr     = {NCH{w_accept}};
    end else begin
      w_ready            = rst_n & w_free[bus.in_sel];
      w_accept           = bus.in_valid & w_ready;
      w_wr[bus.in_sel]   = w_accept;
    end
`else
    w_ready            = rst_n & w_free[bus.in_sel];
    w_accept           = bus.in_valid & w_ready;
    w_wr[bus.in_sel]   = w_accept;
`endif
  end

  // Capture stage: write wins over ack, so refill keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_p1 <= '0;
      r_vld_p1 <= '0;
      r_cnt_p1 <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wr[k]) begin
          r_bus_p1[k] <= bus.in_data;
          r_vld_p1[k] <= 1'b1;
        end else if (bus.out_ack[k]) begin
          r_vld_p1[k] <= 1'b0;
        end
      end
      if (w_accept) begin
        r_cnt_p1 <= r_cnt_p1 + 16'd1;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_bus   = r_bus_p1;
  assign bus.out_valid = r_vld_p1;
  assign bus.xfer_cnt  = r_cnt_p1;

endmodule

// File: tb/tb_demux16_8_buf.sv
// Directed bench for demux16_8_buf: reset, fill, stall, refill stream, counter wrap, broadcast.
module tb_demux16_8_buf;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_tot;

  demux16_8_buf_if bus_if ();

  demux16_8_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane(input int k);
    return bus_if.out_bus[16*k +: 16];
  endfunction

  initial begin
    n_pass = 0;
    n_tot  = 0;

    // Reset with a pending write and acks on every channel.
    rst_n            = 1'b0;
    bus_if.in_data   = 16'h1234;
    bus_if.in_sel    = 3'd0;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ack   = 8'hFF;
`ifdef DEMUX_BCAST_EN
    bus_if.bcast     = 1'b0;
`endif
    tick();
    tick();
    chk("rst_ready", bus_if.in_ready, 1'b0);
    chk("rst_valid", bus_if.out_valid, 8'h00);
    chk("rst_bus", bus_if.out_bus, 128'h0);
    chk("rst_cnt", bus_if.xfer_cnt, 16'h0);
    rst_n           = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.out_ack  = 8'h00;
    tick();

    // Fill every channel without acks.
    for (int k = 0; k < 8; k++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_sel   = 3'(k);
      bus_if.in_data  = 16'h1000 + 16'(k);
      #1;
      chk($sformatf("fill_ready%0d", k), bus_if.in_ready, 1'b1);
      tick();
    end
    bus_if.in_valid = 1'b0;
    chk("fill_valid", bus_if.out_valid, 8'hFF);
    chk("fill_cnt", bus_if.xfer_cnt, 16'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("fill_lane%0d", k), lane(k), 16'h1000 + 16'(k));

    // Full channel rejects a write.
    bus_if.in_valid = 1'b1;
    bus_if.in_sel   = 3'd3;
    bus_if.in_data  = 16'hDEAD;
    #1;
    chk("full_ready", bus_if.in_ready, 1'b0);
    tick();
    bus_if.in_valid = 1'b0;
    chk("full_lane3", lane(3), 16'h1003);
    chk("full_cnt", bus_if.xfer_cnt, 16'd8);
    chk("full_valid", bus_if.out_valid, 8'hFF);

    // Stall on channel 5, released by ack in the accept cycle.
    bus_if.in_valid = 1'b1;
    bus_if.in_sel   = 3'd5;
    bus_if.in_data  = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall_ready%0d", c), bus_if.in_ready, 1'b0);
      tick();
    end
    chk("stall_lane5", lane(5), 16'h1005);
    chk("stall_cnt", bus_if.xfer_cnt, 16'd8);
    bus_if.out_ack = 8'h20;
    #1;
    chk("release_ready", bus_if.in_ready, 1'b1);
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.out_ack  = 8'h00;
    chk("release_lane5", lane(5), 16'hBEEF);
    chk("release_valid", bus_if.out_valid, 8'hFF);
    chk("release_cnt", bus_if.xfer_cnt, 16'd9);

    // 100-word refill stream into channel 2 with ack held high.
    bus_if.in_valid = 1'b1;
    bus_if.in_sel   = 3'd2;
    bus_if.out_ack  = 8'h04;
    for (int i = 0; i < 100; i++) begin
      bus_if.in_data = 16'h2000 + 16'(i);
      #1;
      chk($sformatf("stream_ready%0d", i), bus_if.in_ready, 1'b1);
      chk($sformatf("stream_seen%0d", i), lane(2),
          (i == 0) ? 16'h1002 : 16'h2000 + 16'(i - 1));
      tick();
    end
    bus_if.in_valid = 1'b0;
    chk("stream_last", lane(2), 16'h2063);
    chk("stream_valid", bus_if.out_valid, 8'hFF);
    tick();
    bus_if.out_ack = 8'h00;
    chk("drain_valid", bus_if.out_valid, 8'hFB);
    chk("drain_lane2", lane(2), 16'h2063);
    chk("stream_cnt", bus_if.xfer_cnt, 16'd109);

`ifdef DEMUX_BCAST_EN
    // Empty all but channel 6, then broadcast stalls until 6 is acked.
    bus_if.out_ack = 8'hBF;
    tick();
    bus_if.out_ack = 8'h00;
    chk("bc_pre_valid", bus_if.out_valid, 8'h40);
    bus_if.bcast    = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_sel   = 3'd2;
    bus_if.in_data  = 16'hA5A5;
    #1;
    chk("bc_stall_ready", bus_if.in_ready, 1'b0);
    tick();
    chk("bc_stall_valid", bus_if.out_valid, 8'h40);
    chk("bc_stall_cnt", bus_if.xfer_cnt, 16'd109);
    bus_if.out_ack = 8'h40;
    #1;
    chk("bc_ready", bus_if.in_ready, 1'b1);
    tick();
    bus_if.in_valid = 1'b0;
    bus_if.bcast    = 1'b0;
    bus_if.out_ack  = 8'h00;
    chk("bc_valid", bus_if.out_valid, 8'hFF);
    chk("bc_bus", bus_if.out_bus, {8{16'hA5A5}});
    chk("bc_cnt", bus_if.xfer_cnt, 16'd110);
`endif

    // Reset in the middle of a refill clears everything.
    rst_n           = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_sel   = 3'd0;
    bus_if.out_ack  = 8'hFF;
    tick();
    chk("mid_rst_valid", bus_if.out_valid, 8'h00);
    chk("mid_rst_bus", bus_if.out_bus, 128'h0);
    chk("mid_rst_cnt", bus_if.xfer_cnt, 16'h0);
    rst_n          = 1'b1;
    bus_if.out_ack = 8'h01;

    // 65535 writes to channel 0 with ack held, then one more to wrap.
    for (int i = 0; i < 65535; i++) begin
      bus_if.in_data = 16'(i);
      tick();
    end
    chk("pre_wrap_cnt", bus_if.xfer_cnt, 16'hFFFF);
    chk("pre_wrap_lane0", lane(0), 16'hFFFE);
    bus_if.in_data = 16'h7777;
    tick();
    chk("wrap_cnt", bus_if.xfer_cnt, 16'h0000);
    chk("wrap_lane0", lane(0), 16'h7777);
    bus_if.in_valid = 1'b0;
    tick();
    chk("wrap_drain_valid", bus_if.out_valid, 8'h00);

    // Ack on an empty channel is ignored.
    tick();
    bus_if.out_ack = 8'h00;
    chk("spur_valid", bus_if.out_valid, 8'h00);
    chk("spur_lane0", lane(0), 16'h7777);
    chk("spur_cnt", bus_if.xfer_cnt, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
